arb_request_agent: RTL and testbench

//  Requester-side front end for the fixed-priority (lowest index wins) registered arbiter.

---
 rtl/arb_request_agent.sv | 128 ++++++++++++
 tb/tb_arb_request_agent.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_request_agent.sv
`default_nettype none
// ============================================================================
//  Module      : arb_request_agent
//  Description : Requester-side front end for a fixed-priority registered
//                arbiter. Queues per-channel job pulses as pending counts,
//                drives the request vector, consumes the one-hot grant,
//                reports the granted channel, flags illegal grants and
//                overflowing pushes, and raises per-channel starvation flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_request_agent #(
  parameter int N_REQ        = 4,
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 15,
  localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WAIT_W      = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] push,
  output logic [N_REQ-1:0] push_ready,
  output logic [N_REQ-1:0] out_request,
  input  logic [N_REQ-1:0] in_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] starve,
  output logic             err_grant,
  output logic             err_ovf,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_LIMIT);

  logic [N_REQ-1:0] pend_nz;     // channel has at least one queued job
  logic [N_REQ-1:0] accept;      // push taken into the queue this cycle
  logic [N_REQ-1:0] consume;     // legal grant retires one queued job
  logic             multi_grant; // more than one grant bit set
  logic             orphan;      // grant to a channel with nothing queued
  logic             grant_ok;    // grant vector is legal this cycle
  logic             overflow;    // some push arrived at a full channel
  logic [IDX_W-1:0] grant_enc;   // binary index of the (one-hot) grant

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_grant = (in_grant & (in_grant - N_REQ'(1))) != '0;
  assign orphan      = |(in_grant & ~pend_nz);
  assign grant_ok    = ~multi_grant & ~orphan;
  assign overflow    = |(push & ~push_ready);

  // One-hot to binary; only meaningful when the grant is legal.
  always_comb begin
    grant_enc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_grant[i]) begin
        grant_enc = IDX_W'(i);
      end
    end
  end

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_ch
      logic [CNT_W-1:0]  pend_q;
      logic [WAIT_W-1:0] wait_q;

      assign pend_nz[i]    = pend_q != '0;
      assign push_ready[i] = pend_q != PEND_MAX;
      assign accept[i]     = push[i] & push_ready[i];
      assign consume[i]    = grant_ok & in_grant[i] & pend_nz[i];
      // The last job's request is dropped in its own grant cycle so the
      // arbiter's one-cycle latency cannot hand out a second grant for it.
      assign out_request[i] = pend_nz[i] & ~(in_grant[i] & (pend_q == PEND_ONE));
      assign starve[i]      = wait_q == WAIT_SAT;

      // Pending-job counter: +1 on accepted push, -1 on consumed grant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_q <= '0;
        end else begin
          case ({accept[i], consume[i]})
            2'b10:   pend_q <= pend_q + PEND_ONE;
            2'b01:   pend_q <= pend_q - PEND_ONE;
            default: pend_q <= pend_q;
          endcase
        end
      end

      // Starvation timer: counts cycles of requesting without a grant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wait_q <= '0;
        end else if (out_request[i] & ~in_grant[i]) begin
          if (wait_q != WAIT_SAT) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end else begin
          wait_q <= '0;
        end
      end
    end
  endgenerate

  // Grant report: valid/index registered one cycle after a legal grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      grant_valid <= |consume;
      if (|consume) begin
        grant_idx <= grant_enc;
      end
    end
  end

  // Sticky error flags; a fresh error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_grant <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_grant <= (err_grant & ~err_clr) | ~grant_ok;
      err_ovf   <= (err_ovf & ~err_clr) | overflow;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_request_agent.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_request_agent
//  Description : Self-checking bench for arb_request_agent: fixed vector
//                table, directed corner sequences and randomized traffic
//                against a behavioural model with a model-driven arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_request_agent;
  localparam int N    = 4;
  localparam int MAXP = 7;
  localparam int LIM  = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] push = '0;
  logic [N-1:0] in_grant = '0;
  logic         err_clr = 1'b0;
  logic [N-1:0] push_ready, out_request, starve;
  logic         grant_valid, err_grant, err_ovf;
  logic [1:0]   grant_idx;

  arb_request_agent #(.N_REQ(N), .CNT_W(3), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_ready(push_ready),
    .out_request(out_request), .in_grant(in_grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .starve(starve), .err_grant(err_grant),
    .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int       m_pend [N];
  int       m_wait [N];
  bit       m_gv, m_eg, m_eo;
  int       m_gidx;
  logic [N-1:0] arb_g;   // what a registered lowest-index arbiter would grant next

  typedef struct {
    logic [N-1:0] push;
    logic [N-1:0] grant;
    logic         clr;
    logic [N-1:0] req;
    logic         gv;
    int           gidx;
    logic         eg;
    logic         eo;
  } vec_t;
  vec_t vec [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_wait[i] = 0;
    end
    m_gv = 0; m_eg = 0; m_eo = 0; m_gidx = 0;
    arb_g = '0;
  endtask

  function automatic logic [N-1:0] m_req(input logic [N-1:0] g);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_pend[i] != 0) && !(g[i] && m_pend[i] == 1);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; push = '0; in_grant = '0; err_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_out_request", out_request, 0);
    chk("rst_push_ready", push_ready, 15);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_starve", starve, 0);
    chk("rst_err_grant", err_grant, 0);
    chk("rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of stimulus checked against the model.
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
    logic [N-1:0] req, rdy, stv;
    bit illegal, ovf, any, acc, dec;
    @(negedge clk);
    push = p; in_grant = g; err_clr = c;
    #1;
    req = m_req(g);
    for (int i = 0; i < N; i++) begin
      rdy[i] = m_pend[i] < MAXP;
      stv[i] = m_wait[i] == LIM;
    end
    chk("out_request", out_request, req);
    chk("push_ready", push_ready, rdy);
    chk("starve", starve, stv);
    illegal = $countones(g) > 1;
    for (int i = 0; i < N; i++) if (g[i] && m_pend[i] == 0) illegal = 1;
    ovf = 0; any = 0;
    for (int i = 0; i < N; i++) begin
      acc = p[i] && (m_pend[i] < MAXP);
      if (p[i] && !acc) ovf = 1;
      dec = !illegal && g[i];
      if (dec) begin
        any = 1;
        m_gidx = i;
      end
      m_pend[i] = m_pend[i] + int'(acc) - int'(dec);
      if (req[i] && !g[i]) m_wait[i] = (m_wait[i] < LIM) ? m_wait[i] + 1 : LIM;
      else m_wait[i] = 0;
    end
    m_gv = any;
    m_eg = (m_eg && !c) || illegal;
    m_eo = (m_eo && !c) || ovf;
    arb_g = req & (~req + 1'b1);
    @(posedge clk);
    #1;
    chk("grant_valid", grant_valid, m_gv);
    chk("grant_idx", grant_idx, m_gidx);
    chk("err_grant", err_grant, m_eg);
    chk("err_ovf", err_ovf, m_eo);
  endtask

  initial begin
    logic [N-1:0] p, g;
    // push, grant, clr | req(pre-edge), gv, gidx, eg, eo (post-edge)
    vec[0]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0};
    vec[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 0, 1'b0, 1'b0};
    vec[2]  = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 2, 1'b0, 1'b0};
    vec[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b0};
    vec[4]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 1'b0};
    vec[5]  = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 1'b0, 1'b0};
    vec[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1, 1'b0, 1'b0};
    vec[7]  = '{4'b0000, 4'b0011, 1'b0, 4'b0000, 1'b0, 1, 1'b1, 1'b0};
    vec[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1, 1'b1, 1'b0};
    vec[9]  = '{4'b0000, 4'b1000, 1'b1, 4'b0010, 1'b0, 1, 1'b1, 1'b0};
    vec[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1, 1'b0, 1'b0};
    vec[11] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 1'b0, 1'b0};
    vec[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      push = vec[k].push; in_grant = vec[k].grant; err_clr = vec[k].clr;
      #1;
      chk($sformatf("vec%0d_req", k), out_request, vec[k].req);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gv", k), grant_valid, vec[k].gv);
      chk($sformatf("vec%0d_gidx", k), grant_idx, vec[k].gidx);
      chk($sformatf("vec%0d_eg", k), err_grant, vec[k].eg);
      chk($sformatf("vec%0d_eo", k), err_ovf, vec[k].eo);
    end

    // Overflow on channel 1, then clear
    do_reset();
    repeat (7) step(4'b0010, 4'b0000, 1'b0);
    chk("t3_ready1_low", push_ready[1], 0);
    step(4'b0010, 4'b0000, 1'b0);
    chk("t3_ovf_set", err_ovf, 1);
    step(4'b0000, 4'b0000, 1'b1);
    chk("t3_ovf_clr", err_ovf, 0);
    repeat (20) step(4'b0000, arb_g, 1'b0);
    chk("t3_drained", out_request, 0);

    // Starvation of channel 3 behind a busy channel 0
    do_reset();
    step(4'b1001, 4'b0000, 1'b0);
    repeat (22) step(4'b0001, arb_g, 1'b0);
    chk("t2_starve3_set", starve[3], 1);
    repeat (6) step(4'b0000, arb_g, 1'b0);
    chk("t2_starve3_clr", starve[3], 0);
    chk("t2_idle", out_request, 0);

    // Reset in the middle of a grant with work queued
    do_reset();
    step(4'b1101, 4'b0000, 1'b0);
    step(4'b1001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    push = '0; in_grant = 4'b0001; err_clr = 1'b0;
    #1;
    chk("t6_pre_req", out_request, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_req", out_request, 0);
    chk("t6_ready", push_ready, 15);
    chk("t6_gv", grant_valid, 0);
    chk("t6_starve", starve, 0);
    @(negedge clk);
    in_grant = '0;
    rst_n = 1'b1;
    repeat (3) step(4'b0000, 4'b0000, 1'b0);

    // Randomized traffic with a model-driven arbiter and occasional faults
    do_reset();
    for (int k = 0; k < 600; k++) begin
      p[0] = $urandom_range(0, 99) < 60;
      p[1] = $urandom_range(0, 99) < 40;
      p[2] = $urandom_range(0, 99) < 25;
      p[3] = $urandom_range(0, 99) < 35;
      g = arb_g;
      if ($urandom_range(0, 19) == 0) g = N'($urandom_range(0, 15));
      step(p, g, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
